tmds_rx_channel: RTL and testbench

//  Receive side of one TMDS lane: 1 bit/clk_TMDS serial in, LSB-first (order the TX shifter emits).

---
 rtl/tmds_rx_channel.sv | 198 +++++++++++++++++++
 tb/tb_tmds_rx_channel.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tmds_rx_channel.sv
// One TMDS lane receiver: aligns the serial stream on control tokens, then decodes each word to VD/CD/VDE.
// Outputs register one clock after a word's last bit; free-running input, no backpressure.
module tmds_rx_channel #(
    parameter int LOCK_COUNT    = 8,
    parameter int TOKEN_TIMEOUT = 1023
) (
    input  logic       clk_TMDS,
    input  logic       rst,
    input  logic       serial_i,
    output logic [7:0] VD_o,
    output logic [1:0] CD_o,
    output logic       VDE_o,
    output logic       word_valid_o,
    output logic       locked_o
);
    localparam int CW = $clog2(LOCK_COUNT + 1);
    localparam int TW = $clog2(TOKEN_TIMEOUT + 1);
    localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_COUNT);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TOKEN_TIMEOUT);

    typedef enum logic [1:0] {
        S_SEARCH  = 2'd0,
        S_CONFIRM = 2'd1,
        S_LOCKED  = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [9:0]    win;
    logic [3:0]    ph;
    logic [CW-1:0] cnt;
    logic [TW-1:0] tmo;
    logic [CW-1:0] cnt_inc;
    logic [TW-1:0] tmo_inc;
    logic          boundary;
    logic          is_tok;
    logic [1:0]    tok_cd;
    logic [7:0]    d;
    logic [7:0]    vd_dec;
    logic          tmo_trip;

    // FSM-derived controls for the datapath
    logic acq_start;
    logic cnt_adv;
    logic cnt_clr;
    logic tmo_adv;
    logic tmo_clr;
    logic word_take;

    assign boundary = (ph == 4'd9);
    assign cnt_inc  = cnt + CW'(1);
    assign tmo_inc  = tmo + TW'(1);
    assign tmo_trip = !is_tok && (tmo_inc == TMO_LAST);

    always_comb begin
        is_tok = 1'b1;
        tok_cd = 2'b00;
        case (win)
            10'h354: tok_cd = 2'b00;
            10'h0AB: tok_cd = 2'b01;
            10'h154: tok_cd = 2'b10;
            10'h2AB: tok_cd = 2'b11;
            default: is_tok = 1'b0;
        endcase
    end

    // win[9] undoes the DC-balance inversion, win[8] selects XOR vs XNOR chaining
    always_comb begin
        d         = win[9] ? ~win[7:0] : win[7:0];
        vd_dec    = 8'h00;
        vd_dec[0] = d[0];
        for (int i = 1; i < 8; i++) begin
            vd_dec[i] = win[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
        end
    end

    always_ff @(posedge clk_TMDS or posedge rst) begin
        if (rst) begin
            state <= S_SEARCH;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_SEARCH: begin
                if (is_tok) begin
                    state_nxt = S_CONFIRM;
                end
            end
            S_CONFIRM: begin
                if (boundary) begin
                    if (!is_tok) begin
                        state_nxt = S_SEARCH;
                    end else if (cnt_inc == LOCK_LAST) begin
                        state_nxt = S_LOCKED;
                    end
                end
            end
            S_LOCKED: begin
                if (boundary && tmo_trip) begin
                    state_nxt = S_SEARCH;
                end
            end
            default: state_nxt = S_SEARCH;
        endcase
    end

    always_comb begin
        acq_start = 1'b0;
        cnt_adv   = 1'b0;
        cnt_clr   = 1'b0;
        tmo_adv   = 1'b0;
        tmo_clr   = 1'b0;
        word_take = 1'b0;
        locked_o  = (state == S_LOCKED);
        case (state)
            S_SEARCH: begin
                acq_start = is_tok;
                tmo_clr   = 1'b1;
            end
            S_CONFIRM: begin
                tmo_clr = 1'b1;
                if (boundary) begin
                    cnt_adv = is_tok;
                    cnt_clr = !is_tok;
                end
            end
            S_LOCKED: begin
                if (boundary) begin
                    if (tmo_trip) begin
                        tmo_clr = 1'b1;
                        cnt_clr = 1'b1;
                    end else begin
                        word_take = 1'b1;
                        tmo_clr   = is_tok;
                        tmo_adv   = !is_tok;
                    end
                end
            end
            default: begin
                tmo_clr = 1'b1;
                cnt_clr = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk_TMDS or posedge rst) begin
        if (rst) begin
            win <= 10'h000;
            ph  <= 4'd0;
            cnt <= '0;
            tmo <= '0;
        end else begin
            win <= {serial_i, win[9:1]};
            if (acq_start || boundary) begin
                ph <= 4'd0;
            end else begin
                ph <= ph + 4'd1;
            end
            if (acq_start) begin
                cnt <= CW'(1);
            end else if (cnt_clr) begin
                cnt <= '0;
            end else if (cnt_adv) begin
                cnt <= cnt_inc;
            end
            if (tmo_clr) begin
                tmo <= '0;
            end else if (tmo_adv) begin
                tmo <= tmo_inc;
            end
        end
    end

    // VD_o keeps its last data value across tokens; CD_o keeps its last token value across data
    always_ff @(posedge clk_TMDS or posedge rst) begin
        if (rst) begin
            VD_o         <= 8'h00;
            CD_o         <= 2'b00;
            VDE_o        <= 1'b0;
            word_valid_o <= 1'b0;
        end else begin
            word_valid_o <= word_take;
            if (word_take) begin
                VDE_o <= !is_tok;
                if (is_tok) begin
                    CD_o <= tok_cd;
                end else begin
                    VD_o <= vd_dec;
                end
            end
        end
    end

endmodule

// File: tb/tb_tmds_rx_channel.sv
// Bench for tmds_rx_channel: serial word driver with a scoreboard of expected strobes,
// a vector table of tokens/data, a reference TMDS encoder sweep, and lock/timeout/reset sequences.
module tb_tmds_rx_channel;

    logic       clk_TMDS = 1'b0;
    logic       rst      = 1'b1;
    logic       serial_i = 1'b0;
    logic [7:0] VD_o;
    logic [1:0] CD_o;
    logic       VDE_o;
    logic       word_valid_o;
    logic       locked_o;

    tmds_rx_channel #(
        .LOCK_COUNT   (8),
        .TOKEN_TIMEOUT(1023)
    ) dut (
        .clk_TMDS    (clk_TMDS),
        .rst         (rst),
        .serial_i    (serial_i),
        .VD_o        (VD_o),
        .CD_o        (CD_o),
        .VDE_o       (VDE_o),
        .word_valid_o(word_valid_o),
        .locked_o    (locked_o)
    );

    always #5 clk_TMDS = ~clk_TMDS;

    int cyc = 0;
    always @(posedge clk_TMDS) cyc <= cyc + 1;

    typedef struct {
        logic       vde;
        logic [1:0] cd;
        logic [7:0] vd;
        int         cyc;
    } exp_t;

    typedef struct {
        logic [9:0] word;
        logic       vde;
        logic [1:0] cd;
        logic [7:0] vd;
    } vec_t;

    exp_t       exp_q[$];
    exp_t       mon_e;
    exp_t       drv_e;
    vec_t       vecs[12];
    int         checks = 0;
    int         failures = 0;
    logic [7:0] last_vd = 8'h00;
    logic       prev_locked = 1'b0;
    logic [9:0] enc_w;
    logic [2:0] ctl;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Scoreboard: every strobe must match the oldest expectation, at the predicted cycle
    always @(negedge clk_TMDS) begin
        if (exp_q.size() > 0 && cyc > exp_q[0].cyc) begin
            mon_e = exp_q.pop_front();
            check("missing_strobe", 0, 1);
        end
        if (word_valid_o) begin
            if (exp_q.size() == 0) begin
                check("unexpected_strobe", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                check("strobe_cycle", cyc, mon_e.cyc);
                check("VDE_o", int'(VDE_o), int'(mon_e.vde));
                if (!mon_e.vde) check("CD_o", int'(CD_o), int'(mon_e.cd));
                check("VD_o", int'(VD_o), int'(mon_e.vd));
            end
        end
    end

    function automatic logic [9:0] tmds_enc(input logic [7:0] din, input bit inv);
        logic [8:0] qm;
        int         n1;
        n1    = $countones(din);
        qm    = 9'h000;
        qm[0] = din[0];
        if (n1 > 4 || (n1 == 4 && din[0] == 1'b0)) begin
            for (int i = 1; i < 8; i++) qm[i] = ~(qm[i-1] ^ din[i]);
            qm[8] = 1'b0;
        end else begin
            for (int i = 1; i < 8; i++) qm[i] = qm[i-1] ^ din[i];
            qm[8] = 1'b1;
        end
        return inv ? {1'b1, qm[8], ~qm[7:0]} : {1'b0, qm[8], qm[7:0]};
    endfunction

    function automatic logic [2:0] ctrl_code(input logic [9:0] w);
        case (w)
            10'h354: return 3'b100;
            10'h0AB: return 3'b101;
            10'h154: return 3'b110;
            10'h2AB: return 3'b111;
            default: return 3'b000;
        endcase
    endfunction

    // Drives one word LSB-first; while sending bit 1 it records locked_o as left by the previous word
    task automatic send_word(input logic [9:0] w, input bit exp_strb, input logic vde,
                             input logic [1:0] cd, input logic [7:0] vd);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_TMDS);
            serial_i = w[i];
            if (i == 1) prev_locked = locked_o;
        end
        if (exp_strb) begin
            drv_e.vde = vde;
            drv_e.cd  = cd;
            drv_e.vd  = vd;
            drv_e.cyc = cyc + 2;
            exp_q.push_back(drv_e);
        end
    endtask

    task automatic send_tok(input logic [9:0] w, input logic [1:0] cd, input bit exp_strb);
        send_word(w, exp_strb, 1'b0, cd, last_vd);
    endtask

    task automatic send_dat(input logic [9:0] w, input logic [7:0] vd, input bit exp_strb);
        send_word(w, exp_strb, 1'b1, 2'b00, vd);
        if (exp_strb) last_vd = vd;
    endtask

    task automatic do_reset();
        @(negedge clk_TMDS);
        rst      = 1'b1;
        serial_i = 1'b0;
        repeat (3) @(negedge clk_TMDS);
        rst     = 1'b0;
        last_vd = 8'h00;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{10'h0FF, 1'b1, 2'b00, 8'hFF};
        vecs[1]  = '{10'h2AB, 1'b0, 2'b11, 8'hFF};
        vecs[2]  = '{10'h100, 1'b1, 2'b00, 8'h00};
        vecs[3]  = '{10'h354, 1'b0, 2'b00, 8'h00};
        vecs[4]  = '{10'h055, 1'b1, 2'b00, 8'h01};
        vecs[5]  = '{10'h0AB, 1'b0, 2'b01, 8'h01};
        vecs[6]  = '{10'h200, 1'b1, 2'b00, 8'hFF};
        vecs[7]  = '{10'h154, 1'b0, 2'b10, 8'hFF};
        vecs[8]  = '{10'h3FF, 1'b1, 2'b00, 8'h00};
        vecs[9]  = '{10'h155, 1'b1, 2'b00, 8'hFF};
        vecs[10] = '{10'h2AA, 1'b1, 2'b00, 8'h01};
        vecs[11] = '{10'h2AB, 1'b0, 2'b11, 8'h01};

        // Reset state
        repeat (3) @(negedge clk_TMDS);
        check("rst_VD_o", int'(VD_o), 0);
        check("rst_CD_o", int'(CD_o), 0);
        check("rst_VDE_o", int'(VDE_o), 0);
        check("rst_word_valid_o", int'(word_valid_o), 0);
        check("rst_locked_o", int'(locked_o), 0);
        rst = 1'b0;

        // LOCK_COUNT-1 tokens then a data word must not lock
        for (int i = 0; i < 7; i++) send_tok(10'h354, 2'b00, 1'b0);
        send_dat(10'h0FF, 8'hFF, 1'b0);
        check("t4_locked_after_7_tokens", int'(prev_locked), 0);
        send_tok(10'h354, 2'b00, 1'b0);
        check("t4_locked_after_data", int'(prev_locked), 0);
        send_tok(10'h354, 2'b00, 1'b0);
        check("t4_locked_after_next_token", int'(prev_locked), 0);

        // Misaligned start, then lock on eight tokens
        do_reset();
        repeat (3) begin
            @(negedge clk_TMDS);
            serial_i = 1'($urandom_range(0, 1));
        end
        for (int i = 0; i < 8; i++) begin
            send_tok(10'h354, 2'b00, 1'b0);
            if (i == 7) check("t1_locked_after_7", int'(prev_locked), 0);
        end
        send_tok(10'h354, 2'b00, 1'b1);
        check("t1_locked_after_8", int'(prev_locked), 1);

        // Vector table of tokens and hand-decoded data words
        for (int i = 0; i < 12; i++) begin
            send_word(vecs[i].word, 1'b1, vecs[i].vde, vecs[i].cd, vecs[i].vd);
            last_vd = vecs[i].vd;
        end

        // All bytes in both disparity forms from a reference encoder
        for (int b = 0; b < 256; b++) begin
            for (int inv = 0; inv < 2; inv++) begin
                enc_w = tmds_enc(8'(b), inv != 0);
                ctl   = ctrl_code(enc_w);
                if (ctl[2]) send_tok(enc_w, ctl[1:0], 1'b1);
                else        send_dat(enc_w, 8'(b), 1'b1);
            end
        end
        send_tok(10'h354, 2'b00, 1'b1);
        check("t2_locked_after_sweep", int'(prev_locked), 1);

        // TOKEN_TIMEOUT-1 data words then a token keeps lock
        repeat (1022) send_dat(10'h0FF, 8'hFF, 1'b1);
        send_tok(10'h2AB, 2'b11, 1'b1);
        check("t5_locked_after_1022_data", int'(prev_locked), 1);
        // TOKEN_TIMEOUT data words drop lock, last word not strobed
        repeat (1022) send_dat(10'h0FF, 8'hFF, 1'b1);
        send_dat(10'h0FF, 8'hFF, 1'b0);
        check("t5_locked_before_timeout", int'(prev_locked), 1);
        send_tok(10'h354, 2'b00, 1'b0);
        check("t5_locked_after_timeout", int'(prev_locked), 0);
        for (int i = 0; i < 7; i++) send_tok(10'h354, 2'b00, 1'b0);
        send_tok(10'h354, 2'b00, 1'b1);
        check("t5_relock", int'(prev_locked), 1);

        // Asynchronous reset mid-word while locked
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_TMDS);
            serial_i = 1'(i % 2);
        end
        check("t6_pre_locked", int'(locked_o), 1);
        check("t6_pre_VD_o", int'(VD_o), 8'hFF);
        #2;
        rst = 1'b1;
        #2;
        check("t6_rst_VD_o", int'(VD_o), 0);
        check("t6_rst_CD_o", int'(CD_o), 0);
        check("t6_rst_VDE_o", int'(VDE_o), 0);
        check("t6_rst_word_valid_o", int'(word_valid_o), 0);
        check("t6_rst_locked_o", int'(locked_o), 0);
        repeat (2) @(negedge clk_TMDS);
        rst      = 1'b0;
        serial_i = 1'b0;
        last_vd  = 8'h00;
        for (int i = 0; i < 8; i++) begin
            send_tok(10'h154, 2'b10, 1'b0);
            if (i == 7) check("t6_locked_after_7", int'(prev_locked), 0);
        end
        send_tok(10'h154, 2'b10, 1'b1);
        check("t6_locked_after_8", int'(prev_locked), 1);

        repeat (4) @(negedge clk_TMDS);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
